// File: rtl/btb_bht_1bit.sv
// btb_bht_1bit
//   Fetch-stage branch predictor: fully-associative branch target buffer
//   with a 1-bit direction history per entry and FIFO replacement.
//
//   Fetch side (combinational, 0-cycle):
//     PCF           current fetch PC
//     PredictedPCF  next fetch PC (hit & taken-history ? target : PCF+4)
//     BranchFlagsF  [0]=hit, [1]=predicted taken
//     BranchIndexF  index of hit entry (0 on miss)
//   EX side:
//     BranchE, BranchTakenE, PCE, BrTargetE, BranchFlagsE, BranchIndexE
//       resolved branch plus the tags it carried from fetch
//     MispredictE   combinational redirect request
//     CorrectPCE    combinational redirect target
//   Statistics:
//     BranchCount, MispredictCount  wrap at 2^32
//
//   There is no valid/ready handshake: fetch and EX sides are sampled every
//   cycle, and an EX slot takes effect only when BranchE=1. Table writes land
//   on posedge clk, so a same-cycle lookup always sees the old contents.
module btb_bht_1bit #(
  parameter int ENTRIES = 8,
  parameter int IDX_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      PCF,
  output logic [31:0]      PredictedPCF,
  output logic [1:0]       BranchFlagsF,
  output logic [IDX_W-1:0] BranchIndexF,
  input  logic             BranchE,
  input  logic             BranchTakenE,
  input  logic [31:0]      PCE,
  input  logic [31:0]      BrTargetE,
  input  logic [1:0]       BranchFlagsE,
  input  logic [IDX_W-1:0] BranchIndexE,
  output logic             MispredictE,
  output logic [31:0]      CorrectPCE,
  output logic [31:0]      BranchCount,
  output logic [31:0]      MispredictCount
);

  logic             valid_q  [ENTRIES];
  logic [31:0]      tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic             hist_q   [ENTRIES];
  logic [IDX_W-1:0] alloc_ptr;

  logic             f_hit;
  logic [IDX_W-1:0] f_idx;
  logic             f_taken;
  logic             e_hit;
  logic [IDX_W-1:0] e_idx;
  logic             pred_taken_e;
  logic             upd_existing;
  logic             do_alloc;
  logic [IDX_W-1:0] upd_idx;

  // Fetch lookup. Allocation keeps tags unique, so at most one entry matches.
  always_comb begin
    f_hit = 1'b0;
    f_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == PCF)) begin
        f_hit = 1'b1;
        f_idx = IDX_W'(i);
      end
    end
  end

  assign f_taken      = f_hit & hist_q[f_idx];
  assign BranchFlagsF = {f_taken, f_hit};
  assign BranchIndexF = f_idx;
  assign PredictedPCF = f_taken ? target_q[f_idx] : (PCF + 32'd4);

  // Second lookup on the EX PC. It catches a branch that missed at fetch but
  // was allocated by an older in-flight copy of itself, so the table never
  // holds two entries with the same tag.
  always_comb begin
    e_hit = 1'b0;
    e_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == PCE)) begin
        e_hit = 1'b1;
        e_idx = IDX_W'(i);
      end
    end
  end

  assign pred_taken_e = BranchFlagsE[0] & BranchFlagsE[1];
  assign MispredictE  = BranchE & (pred_taken_e != BranchTakenE);
  assign CorrectPCE   = BranchTakenE ? BrTargetE : (PCE + 32'd4);

  // Hit path and the in-flight-duplicate path both rewrite an existing entry;
  // the duplicate path only arises when taken, so hist<=BranchTakenE covers both.
  assign upd_existing = BranchFlagsE[0] | (BranchTakenE & e_hit);
  assign upd_idx      = BranchFlagsE[0] ? BranchIndexE : e_idx;
  assign do_alloc     = ~BranchFlagsE[0] & BranchTakenE & ~e_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        hist_q[i]   <= 1'b0;
      end
      alloc_ptr       <= '0;
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else if (BranchE) begin
      BranchCount <= BranchCount + 32'd1;
      if (MispredictE) begin
        MispredictCount <= MispredictCount + 32'd1;
      end
      if (upd_existing) begin
        hist_q[upd_idx] <= BranchTakenE;
        if (BranchTakenE) begin
          target_q[upd_idx] <= BrTargetE;
        end
      end else if (do_alloc) begin
        // FIFO replacement: the pointer wraps naturally since ENTRIES = 2^IDX_W.
        valid_q[alloc_ptr]  <= 1'b1;
        tag_q[alloc_ptr]    <= PCE;
        target_q[alloc_ptr] <= BrTargetE;
        hist_q[alloc_ptr]   <= 1'b1;
        alloc_ptr           <= alloc_ptr + IDX_W'(1);
      end
    end
  end

endmodule

// File: doc/btb_bht_1bit.md
Name: btb_bht_1bit

Overview:
- Fetch-stage branch predictor: an 8-entry fully-associative branch target buffer. Each entry holds a 1-bit history (BHT) bit.
- Sits upstream of the IF/ID segment register.
  - Produces the next-PC prediction plus BranchFlagsF/BranchIndexF, which travel down the pipe alongside PCF.
  - Consumes the same tags back from EX to update the table, flag mispredictions and count statistics.

Parameters:
ENTRIES, 8, number of BTB entries (power of two)
IDX_W, 3, log2(ENTRIES); width of BranchIndexF/E

Ports:
clk  input  1  pipeline clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
PCF  input  32  current fetch PC
PredictedPCF  output  32  next fetch PC chosen by predictor
BranchFlagsF  output  2  [0]=BTB hit, [1]=predicted taken (valid only when [0]=1)
BranchIndexF  output  IDX_W  index of hit entry (0 on miss)
BranchE  input  1  EX holds a real conditional branch (0 for bubbles/flushed slots)
BranchTakenE  input  1  resolved direction in EX
PCE  input  32  PC of branch in EX
BrTargetE  input  32  resolved branch target in EX
BranchFlagsE  input  2  flags carried from fetch for this branch
BranchIndexE  input  IDX_W  index carried from fetch for this branch
MispredictE  output  1  EX must redirect fetch and flush IF/ID, ID/EX
CorrectPCE  output  32  redirect PC when MispredictE=1
BranchCount  output  32  number of resolved branches
MispredictCount  output  32  number of mispredictions

Behaviour:
- Entry state: valid, tag[31:0] (full PC), target[31:0], hist (1 bit). Allocation pointer alloc_ptr[IDX_W-1:0].
- Reset (async, rst_n=0):
  - all valid=0, hist=0, alloc_ptr=0, BranchCount=0, MispredictCount=0.
  - Outputs follow combinationally: PredictedPCF=PCF+4, BranchFlagsF=0, BranchIndexF=0.
- Lookup (combinational, 0-cycle):
  - hit = some valid entry has tag==PCF. At most one can match; allocation guarantees uniqueness.
  - BranchFlagsF={hit&hist, hit}; BranchIndexF=hit index else 0.
  - PredictedPCF = (hit&&hist) ? target : PCF+4, with 32-bit wrap.
- Resolution (combinational, EX):
  - predTaken = BranchFlagsE[0]&BranchFlagsE[1].
  - MispredictE = BranchE & (predTaken != BranchTakenE).
  - CorrectPCE = BranchTakenE ? BrTargetE : PCE+4.
  - MispredictE=0 whenever BranchE=0.
- Update (posedge clk, only when BranchE=1):
  - Hit path (BranchFlagsE[0]=1): hist[BranchIndexE]<=BranchTakenE. If taken, target[BranchIndexE]<=BrTargetE. Tag and valid unchanged.
  - Miss path, taken, PCE already present in a valid entry (an in-flight duplicate allocated since fetch): update that entry as on the hit path; no allocation, alloc_ptr unchanged.
  - Miss path, taken, PCE absent: write entry alloc_ptr with valid=1, tag=PCE, target=BrTargetE, hist=1. Then alloc_ptr<=alloc_ptr+1, wrapping ENTRIES-1 -> 0 (FIFO replacement; overwrites valid entries).
  - Miss path, not taken: no table change.
  - BranchCount<=BranchCount+1. MispredictCount increments when MispredictE=1. Both wrap at 2^32.
- Simultaneous lookup and update of the same entry/PC:
  - lookup sees pre-update contents in that cycle; the new contents are visible from the next cycle.
  - No write-to-read bypass.
- Stall/flush: block has no enable.
  - Fetch stall holds PCF, so outputs hold.
  - Flushed slots reach EX with BranchE=0 and flags=0, so they cause no update.
- Reset asserted mid-operation: table and counters clear immediately. A pending EX update in that cycle is discarded.

Test Plan:
- Reset, PCF=0x100 -> PredictedPCF=0x104, BranchFlagsF=2'b00, BranchIndexF=0. Counters 0.
- Cold taken branch: BranchE=1, PCE=0x20, BrTargetE=0x08, flags 00, taken.
  - Same cycle -> MispredictE=1, CorrectPCE=0x08.
  - Next cycle, PCF=0x20 -> PredictedPCF=0x08, flags 2'b11, index 0.
  - MispredictCount=1, alloc_ptr=1.
- Hit then not-taken: resolve PCE=0x20, flags 11, index 0, taken=0.
  - Same cycle -> MispredictE=1, CorrectPCE=0x24.
  - Next lookup of 0x20 -> flags 2'b01, PredictedPCF=0x24. BranchCount=2.
- Miss not-taken: PCE=0x40, taken=0, flags 00.
  - Same cycle -> MispredictE=0.
  - Next cycle -> 0x40 still misses, alloc_ptr unchanged, BranchCount increments.
- Wrap/replacement: 9 distinct taken cold branches at PCs 0x100..0x120 step 4.
  - Ninth overwrites entry 0; lookup of 0x100 misses, 0x120 hits at index 0.
- Duplicate in flight: two back-to-back cold taken resolutions of PCE=0x60, both flags 00.
  - Only one entry allocated; alloc_ptr advances by 1 total.
- Same-cycle hazard: PCF=0x20 while 0x20's hit entry is updated to not-taken.
  - That cycle's flags still show the old hist; the new value appears in the following cycle.
